graphics_buffer_controller: RTL and testbench
=============================================

// Module: graphics_buffer_controller
// PURPOSE
//  Sequences the graphics framebuffer behind the SPI command decoder. Owns the single
//  framebuffer write port, arbitrating between the internal clear sweeper and sprite pixel writes.
//  Manages double buffering: all writes go to the back buffer, and a show request swaps buffers
//  only on the display's frame boundary.
// PARAMETERS
//  PIXELS      256000  pixels per buffer (640x400)
//  ADDR_WIDTH  18      framebuffer address width; must satisfy 2**ADDR_WIDTH >= PIXELS
// PORTS
//  clock_in               in   1   system clock, 72MHz
//  reset_in               in   1   synchronous reset, active-high
//  clear_request_in       in   1   1-cycle pulse: clear back buffer
//  show_request_in        in   1   1-cycle pulse: swap buffers at next frame boundary
//  frame_done_in          in   1   1-cycle pulse from display at start of vblank
//  pixel_valid_in         in   1   sprite pixel write request
//  pixel_addr_in          in   ADDR_WIDTH  sprite pixel address
//  pixel_color_in         in   4   palette index
//  pixel_ready_out        out  1   pixel accepted when valid&ready
//  fb_write_enable_out    out  1   framebuffer write strobe
//  fb_write_buffer_out    out  1   buffer written (always current back)
//  fb_write_addr_out      out  ADDR_WIDTH  write address
//  fb_write_data_out      out  4   write data
//  display_buffer_out     out  1   buffer scanned by display (front)
//  busy_out               out  1   state != IDLE or any request pending
// BEHAVIOUR
//  - Reset: state IDLE; display_buffer_out=0; back=1; fb_write_enable_out=0; addr/data=0;
//    pixel_ready_out=0; busy_out=0; pending flags and counters cleared. A reset mid-clear or
//    mid-swap aborts the operation immediately; no swap occurs.
//  - States: IDLE, CLEAR, SWAP_WAIT.
//  - IDLE: pixel_ready_out=1 only if no pending clear/show. A pending clear has priority: enter
//    CLEAR. Otherwise a pending show enters SWAP_WAIT. Pulses arriving in the same cycle are
//    latched; they are acted on from the next cycle.
//  - CLEAR: one write per cycle, addr 0..PIXELS-1, data 0, to the back buffer.
//    pixel_ready_out=0. After addr PIXELS-1 is issued, return to IDLE; the clear takes exactly
//    PIXELS cycles.
//    A clear_request_in during CLEAR is absorbed (no restart). A show_request_in is latched.
//  - SWAP_WAIT: pixel_ready_out=0, no writes. On frame_done_in, toggle display_buffer_out and
//    back in the same edge, then go to IDLE. A clear_request_in here is latched and runs after
//    the swap, so it clears the new back buffer. Duplicate show requests are absorbed.
//  - frame_done_in outside SWAP_WAIT: ignored.
//  - Sprite path: on valid&ready, write registered with 1-cycle latency. fb_write_enable_out=1
//    the next cycle, with that addr/color. An address >= PIXELS is accepted but produces no write.
//  - fb_write_enable_out is never asserted in SWAP_WAIT. fb_write_buffer_out always equals
//    ~display_buffer_out.
// CONFIGURATION
//  GRAPHICS_BUFFER_STATS_EN defined: adds outputs dropped_pixels_out[15:0] and swaps_out[15:0].
//    Both are saturating counters, reset to 0.
//    dropped_pixels_out counts accepted out-of-range pixels.
//    swaps_out counts completed swaps.
//  Not defined: these ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  - Reset, then 3 pixels at addr 0/5/9, color 7 -> 3 write strobes 1 cycle after each
//    acceptance; buffer=1; display_buffer_out=0.
//  - clear_request_in with PIXELS=16 -> 16 consecutive writes addr 0..15, data 0;
//    pixel_ready_out low throughout; IDLE after.
//  - show_request_in, frame_done_in 10 cycles later -> display_buffer_out toggles to 1 on that
//    edge; fb_write_buffer_out=0; no writes in between.
//  - clear and show pulsed in the same cycle -> full clear, then SWAP_WAIT; swap on the next
//    frame_done only.
//  - show, then clear during SWAP_WAIT, then frame_done -> swap, then clear of the new back buffer.
//  - reset_in asserted at clear addr 8 -> writes stop next cycle, all outputs at reset values;
//    pixel at addr PIXELS -> no write, dropped_pixels_out=1 (STATS_EN).

Source files
------------

// File: rtl/graphics_buffer_controller.sv
// graphics_buffer_controller: owns the framebuffer write port and sequences
// back-buffer clears and double-buffer swaps. Swaps are taken only on the
// display frame boundary.
// Optional build macro GRAPHICS_BUFFER_STATS_EN adds the saturating
// dropped_pixels_out / swaps_out counters.
module graphics_buffer_controller #(
    parameter int unsigned PIXELS     = 256000,
    parameter int unsigned ADDR_WIDTH = 18
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  clear_request_in,
    input  logic                  show_request_in,
    input  logic                  frame_done_in,
    input  logic                  pixel_valid_in,
    input  logic [ADDR_WIDTH-1:0] pixel_addr_in,
    input  logic [3:0]            pixel_color_in,
    output logic                  pixel_ready_out,
    output logic                  fb_write_enable_out,
    output logic                  fb_write_buffer_out,
    output logic [ADDR_WIDTH-1:0] fb_write_addr_out,
    output logic [3:0]            fb_write_data_out,
    output logic                  display_buffer_out,
`ifdef GRAPHICS_BUFFER_STATS_EN
    output logic [15:0]           dropped_pixels_out,
    output logic [15:0]           swaps_out,
`endif
    output logic                  busy_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(PIXELS - 1);
    localparam logic [ADDR_WIDTH:0]   PIXEL_LIMIT = (ADDR_WIDTH + 1)'(PIXELS);

    state_t                  state;
    state_t                  next_state;
    logic                    clear_pending;
    logic                    show_pending;
    logic [ADDR_WIDTH-1:0]   clear_addr;
    logic                    display_buffer;
    logic                    sprite_we;
    logic [ADDR_WIDTH-1:0]   sprite_addr;
    logic [3:0]              sprite_data;
    logic                    start_clear;
    logic                    start_swap;
    logic                    swap_now;
    logic                    accept;
    logic                    in_range;

    assign accept   = pixel_valid_in && pixel_ready_out;
    assign in_range = {1'b0, pixel_addr_in} < PIXEL_LIMIT;

    // State register
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode, handshake and write-port mux
    always_comb begin
        next_state          = state;
        pixel_ready_out     = 1'b0;
        start_clear         = 1'b0;
        start_swap          = 1'b0;
        swap_now            = 1'b0;
        fb_write_enable_out = sprite_we;
        fb_write_addr_out   = sprite_addr;
        fb_write_data_out   = sprite_data;
        case (state)
            IDLE: begin
                // Ready is held low while reset is asserted so the reset
                // values of all outputs are visible during reset.
                pixel_ready_out = !reset_in && !clear_pending && !show_pending;
                if (clear_pending) begin
                    start_clear = 1'b1;
                    next_state  = CLEAR;
                end else if (show_pending) begin
                    start_swap = 1'b1;
                    next_state = SWAP_WAIT;
                end
            end
            CLEAR: begin
                fb_write_enable_out = 1'b1;
                fb_write_addr_out   = clear_addr;
                fb_write_data_out   = '0;
                if (clear_addr == LAST_ADDR) begin
                    next_state = IDLE;
                end
            end
            SWAP_WAIT: begin
                fb_write_enable_out = 1'b0;
                if (frame_done_in) begin
                    swap_now   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latches: a clear during CLEAR and a show during SWAP_WAIT are absorbed
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            clear_pending <= 1'b0;
            show_pending  <= 1'b0;
        end else begin
            if (start_clear) begin
                clear_pending <= 1'b0;
            end else if (clear_request_in && state != CLEAR) begin
                clear_pending <= 1'b1;
            end
            if (start_swap) begin
                show_pending <= 1'b0;
            end else if (show_request_in && state != SWAP_WAIT) begin
                show_pending <= 1'b1;
            end
        end
    end

    // Clear sweep address and front/back buffer selection
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            clear_addr     <= '0;
            display_buffer <= 1'b0;
        end else begin
            clear_addr <= (state == CLEAR) ? clear_addr + 1'b1 : '0;
            if (swap_now) begin
                display_buffer <= ~display_buffer;
            end
        end
    end

    // Sprite write register: one-cycle latency, out-of-range pixels dropped
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            sprite_we   <= 1'b0;
            sprite_addr <= '0;
            sprite_data <= '0;
        end else begin
            sprite_we <= accept && in_range;
            if (accept && in_range) begin
                sprite_addr <= pixel_addr_in;
                sprite_data <= pixel_color_in;
            end
        end
    end

    assign display_buffer_out  = display_buffer;
    assign fb_write_buffer_out = ~display_buffer;
    assign busy_out            = (state != IDLE) || clear_pending || show_pending;

`ifdef GRAPHICS_BUFFER_STATS_EN
    // Saturating statistics counters
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            dropped_pixels_out <= '0;
            swaps_out          <= '0;
        end else begin
            if (accept && !in_range && dropped_pixels_out != '1) begin
                dropped_pixels_out <= dropped_pixels_out + 1'b1;
            end
            if (swap_now && swaps_out != '1) begin
                swaps_out <= swaps_out + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_graphics_buffer_controller.sv
// Self-checking bench for graphics_buffer_controller with a small (16 pixel)
// framebuffer. Expected writes go into a scoreboard tagged with the cycle in
// which they must appear; a negedge monitor pops and compares them.
module tb_graphics_buffer_controller;

    localparam int unsigned PIXELS = 16;
    localparam int unsigned AW     = 5;

    logic          clock_in = 1'b0;
    logic          reset_in = 1'b0;
    logic          clear_request_in = 1'b0;
    logic          show_request_in = 1'b0;
    logic          frame_done_in = 1'b0;
    logic          pixel_valid_in = 1'b0;
    logic [AW-1:0] pixel_addr_in = '0;
    logic [3:0]    pixel_color_in = '0;
    logic          pixel_ready_out;
    logic          fb_write_enable_out;
    logic          fb_write_buffer_out;
    logic [AW-1:0] fb_write_addr_out;
    logic [3:0]    fb_write_data_out;
    logic          display_buffer_out;
    logic          busy_out;
`ifdef GRAPHICS_BUFFER_STATS_EN
    logic [15:0]   dropped_pixels_out;
    logic [15:0]   swaps_out;
`endif

    graphics_buffer_controller #(
        .PIXELS     (PIXELS),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock_in            (clock_in),
        .reset_in            (reset_in),
        .clear_request_in    (clear_request_in),
        .show_request_in     (show_request_in),
        .frame_done_in       (frame_done_in),
        .pixel_valid_in      (pixel_valid_in),
        .pixel_addr_in       (pixel_addr_in),
        .pixel_color_in      (pixel_color_in),
        .pixel_ready_out     (pixel_ready_out),
        .fb_write_enable_out (fb_write_enable_out),
        .fb_write_buffer_out (fb_write_buffer_out),
        .fb_write_addr_out   (fb_write_addr_out),
        .fb_write_data_out   (fb_write_data_out),
        .display_buffer_out  (display_buffer_out),
`ifdef GRAPHICS_BUFFER_STATS_EN
        .dropped_pixels_out  (dropped_pixels_out),
        .swaps_out           (swaps_out),
`endif
        .busy_out            (busy_out)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int unsigned   cyc;
        logic          bsel;
        logic [AW-1:0] addr;
        logic [3:0]    data;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    logic        exp_display = 1'b0;

    always @(posedge clock_in) cyc <= cyc + 1;

    // Write monitor: every strobe must match the head of the scoreboard
    always @(negedge clock_in) begin
        wr_t e;
        total++;
        if (fb_write_buffer_out !== ~display_buffer_out) begin
            bad++;
            $display("FAIL buffer_relation cyc=%0d got=%b want=%b", cyc, fb_write_buffer_out, ~display_buffer_out);
        end
        if (fb_write_enable_out === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0d buf=%b", cyc, fb_write_addr_out, fb_write_data_out, fb_write_buffer_out);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.cyc || fb_write_buffer_out !== e.bsel || fb_write_addr_out !== e.addr || fb_write_data_out !== e.data) begin
                    bad++;
                    $display("FAIL write got cyc=%0d buf=%b addr=%0d data=%0d want cyc=%0d buf=%b addr=%0d data=%0d",
                             cyc, fb_write_buffer_out, fb_write_addr_out, fb_write_data_out, e.cyc, e.bsel, e.addr, e.data);
                end
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            total++;
            bad++;
            $display("FAIL missing_write cyc=%0d want addr=%0d at cyc=%0d", cyc, exp_q[0].addr, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic push_wr(input int unsigned c, input logic b, input logic [AW-1:0] a, input logic [3:0] d);
        wr_t e;
        e.cyc = c; e.bsel = b; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got=%0d pending want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        tick(); tick();
        total += 7;
        if (fb_write_enable_out !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", fb_write_enable_out); end
        if (fb_write_addr_out !== '0) begin bad++; $display("FAIL reset_addr got=%0d want=0", fb_write_addr_out); end
        if (fb_write_data_out !== '0) begin bad++; $display("FAIL reset_data got=%0d want=0", fb_write_data_out); end
        if (display_buffer_out !== 1'b0) begin bad++; $display("FAIL reset_display got=%b want=0", display_buffer_out); end
        if (fb_write_buffer_out !== 1'b1) begin bad++; $display("FAIL reset_back got=%b want=1", fb_write_buffer_out); end
        if (pixel_ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", pixel_ready_out); end
        if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_out); end
        reset_in = 1'b0;
        exp_display = 1'b0;
        tick();
        total++;
        if (pixel_ready_out !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", pixel_ready_out); end
    endtask

    task automatic test_pixels();
        logic [AW-1:0] addrs [3];
        addrs[0] = 5'd0; addrs[1] = 5'd5; addrs[2] = 5'd9;
        for (int i = 0; i < 3; i++) begin
            pixel_valid_in = 1'b1; pixel_addr_in = addrs[i]; pixel_color_in = 4'd7;
            total++;
            if (pixel_ready_out !== 1'b1) begin bad++; $display("FAIL pixel_ready got=%b want=1", pixel_ready_out); end
            push_wr(cyc + 1, ~exp_display, addrs[i], 4'd7);
            tick();
        end
        // back-to-back random pixels, in range
        for (int i = 0; i < 8; i++) begin
            pixel_addr_in  = AW'($urandom_range(0, PIXELS - 1));
            pixel_color_in = 4'($urandom_range(0, 15));
            push_wr(cyc + 1, ~exp_display, pixel_addr_in, pixel_color_in);
            tick();
        end
        pixel_valid_in = 1'b0;
        wait_drain("pixels");
        total++;
        if (display_buffer_out !== 1'b0) begin bad++; $display("FAIL pixels_display got=%b want=0", display_buffer_out); end
    endtask

    task automatic test_clear();
        int unsigned k;
        k = cyc;
        clear_request_in = 1'b1;
        for (int i = 0; i < int'(PIXELS); i++) push_wr(k + 2 + i, ~exp_display, AW'(i), 4'd0);
        tick();
        clear_request_in = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            frame_done_in    = (j == 4);
            clear_request_in = (j == 7);
            total += 2;
            if (pixel_ready_out !== 1'b0) begin bad++; $display("FAIL clear_ready j=%0d got=%b want=0", j, pixel_ready_out); end
            if (busy_out !== 1'b1) begin bad++; $display("FAIL clear_busy j=%0d got=%b want=1", j, busy_out); end
            tick();
        end
        frame_done_in = 1'b0; clear_request_in = 1'b0;
        total += 3;
        if (pixel_ready_out !== 1'b1) begin bad++; $display("FAIL clear_end_ready got=%b want=1", pixel_ready_out); end
        if (busy_out !== 1'b0) begin bad++; $display("FAIL clear_end_busy got=%b want=0", busy_out); end
        if (display_buffer_out !== exp_display) begin bad++; $display("FAIL clear_display got=%b want=%b", display_buffer_out, exp_display); end
        for (int i = 0; i < 4; i++) tick();
        wait_drain("clear");
    endtask

    task automatic test_show();
        show_request_in = 1'b1;
        tick();
        show_request_in = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            show_request_in = (j == 5);
            pixel_valid_in  = (j == 3);
            pixel_addr_in   = 5'd2;
            frame_done_in   = (j == 10);
            total += 2;
            if (pixel_ready_out !== 1'b0) begin bad++; $display("FAIL show_ready j=%0d got=%b want=0", j, pixel_ready_out); end
            if (display_buffer_out !== exp_display) begin bad++; $display("FAIL show_early_swap j=%0d got=%b want=%b", j, display_buffer_out, exp_display); end
            tick();
        end
        show_request_in = 1'b0; pixel_valid_in = 1'b0; frame_done_in = 1'b0;
        exp_display = ~exp_display;
        total += 4;
        if (display_buffer_out !== exp_display) begin bad++; $display("FAIL show_swap got=%b want=%b", display_buffer_out, exp_display); end
        if (fb_write_buffer_out !== ~exp_display) begin bad++; $display("FAIL show_back got=%b want=%b", fb_write_buffer_out, ~exp_display); end
        if (pixel_ready_out !== 1'b1) begin bad++; $display("FAIL show_end_ready got=%b want=1", pixel_ready_out); end
        if (busy_out !== 1'b0) begin bad++; $display("FAIL show_end_busy got=%b want=0", busy_out); end
        wait_drain("show");
    endtask

    task automatic test_clear_and_show();
        int unsigned k;
        k = cyc;
        clear_request_in = 1'b1; show_request_in = 1'b1;
        for (int i = 0; i < int'(PIXELS); i++) push_wr(k + 2 + i, ~exp_display, AW'(i), 4'd0);
        tick();
        clear_request_in = 1'b0; show_request_in = 1'b0;
        for (int j = 1; j <= 22; j++) begin
            frame_done_in = (j == 6) || (j == 18) || (j == 22);
            total += 2;
            if (pixel_ready_out !== 1'b0) begin bad++; $display("FAIL cs_ready j=%0d got=%b want=0", j, pixel_ready_out); end
            if (display_buffer_out !== exp_display) begin bad++; $display("FAIL cs_early_swap j=%0d got=%b want=%b", j, display_buffer_out, exp_display); end
            tick();
        end
        frame_done_in = 1'b0;
        exp_display = ~exp_display;
        total += 2;
        if (display_buffer_out !== exp_display) begin bad++; $display("FAIL cs_swap got=%b want=%b", display_buffer_out, exp_display); end
        if (pixel_ready_out !== 1'b1) begin bad++; $display("FAIL cs_end_ready got=%b want=1", pixel_ready_out); end
        wait_drain("clear_show");
    endtask

    task automatic test_show_then_clear();
        int unsigned k;
        k = cyc;
        show_request_in = 1'b1;
        tick();
        show_request_in = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            clear_request_in = (j == 4);
            frame_done_in    = (j == 7);
            tick();
        end
        clear_request_in = 1'b0; frame_done_in = 1'b0;
        exp_display = ~exp_display;
        // swap landed at k+8; clear of the new back buffer runs k+9..k+24
        for (int i = 0; i < int'(PIXELS); i++) push_wr(k + 9 + i, ~exp_display, AW'(i), 4'd0);
        total += 2;
        if (display_buffer_out !== exp_display) begin bad++; $display("FAIL sc_swap got=%b want=%b", display_buffer_out, exp_display); end
        if (pixel_ready_out !== 1'b0) begin bad++; $display("FAIL sc_ready got=%b want=0", pixel_ready_out); end
        for (int j = 8; j < 25; j++) tick();
        total++;
        if (pixel_ready_out !== 1'b1) begin bad++; $display("FAIL sc_end_ready got=%b want=1", pixel_ready_out); end
        wait_drain("show_clear");
    endtask

    task automatic test_reset_mid_clear();
        int unsigned k;
        k = cyc;
        clear_request_in = 1'b1;
        for (int i = 0; i <= 8; i++) push_wr(k + 2 + i, ~exp_display, AW'(i), 4'd0);
        tick();
        clear_request_in = 1'b0;
        for (int j = 1; j < 10; j++) begin
            show_request_in = (j == 5);
            tick();
        end
        show_request_in = 1'b0;
        reset_in = 1'b1;
        tick();
        exp_display = 1'b0;
        total += 7;
        if (fb_write_enable_out !== 1'b0) begin bad++; $display("FAIL rmc_we got=%b want=0", fb_write_enable_out); end
        if (fb_write_addr_out !== '0) begin bad++; $display("FAIL rmc_addr got=%0d want=0", fb_write_addr_out); end
        if (fb_write_data_out !== '0) begin bad++; $display("FAIL rmc_data got=%0d want=0", fb_write_data_out); end
        if (display_buffer_out !== 1'b0) begin bad++; $display("FAIL rmc_display got=%b want=0", display_buffer_out); end
        if (fb_write_buffer_out !== 1'b1) begin bad++; $display("FAIL rmc_back got=%b want=1", fb_write_buffer_out); end
        if (pixel_ready_out !== 1'b0) begin bad++; $display("FAIL rmc_ready got=%b want=0", pixel_ready_out); end
        if (busy_out !== 1'b0) begin bad++; $display("FAIL rmc_busy got=%b want=0", busy_out); end
        tick();
        reset_in = 1'b0;
        tick();
        total += 2;
        if (pixel_ready_out !== 1'b1) begin bad++; $display("FAIL rmc_after_ready got=%b want=1", pixel_ready_out); end
        if (busy_out !== 1'b0) begin bad++; $display("FAIL rmc_after_busy got=%b want=0", busy_out); end
        for (int i = 0; i < 20; i++) tick();
        wait_drain("reset_mid_clear");
    endtask

    task automatic test_out_of_range();
        pixel_valid_in = 1'b1; pixel_addr_in = AW'(PIXELS); pixel_color_in = 4'd3;
        total++;
        if (pixel_ready_out !== 1'b1) begin bad++; $display("FAIL oor_ready got=%b want=1", pixel_ready_out); end
        tick();
        pixel_addr_in = AW'(PIXELS - 1); pixel_color_in = 4'd12;
        push_wr(cyc + 1, ~exp_display, AW'(PIXELS - 1), 4'd12);
        tick();
        pixel_valid_in = 1'b0;
        wait_drain("out_of_range");
`ifdef GRAPHICS_BUFFER_STATS_EN
        total += 2;
        if (dropped_pixels_out !== 16'd1) begin bad++; $display("FAIL stats_dropped got=%0d want=1", dropped_pixels_out); end
        if (swaps_out !== 16'd0) begin bad++; $display("FAIL stats_swaps got=%0d want=0", swaps_out); end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_pixels();
        test_clear();
        test_show();
        test_clear_and_show();
        test_show_then_clear();
        test_reset_mid_clear();
        test_out_of_range();
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
